image_line_fetcher: RTL and testbench

Per-scanline SDRAM fetch stage that sits directly upstream of the background and mask image FIFOs. On each line-start pulse it bursts one full line of interleaved image data from the SDRAM burst port and re-requests after short bursts. It unpacks each 16-bit word into a background byte and a mask byte, and emits packed 24-bit background and mask pixels with a write strobe for the FIFOs. It also drives the FIFO clear.

---
 rtl/image_line_fetcher.sv | 190 +++++++++++++++++++
 tb/tb_image_line_fetcher.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_line_fetcher.sv
// Per-line SDRAM burst fetch, unpacking 16-bit words into 24-bit background/mask pixels.
// sd_rd_req one cycle after line_start; pixel one cycle after third word; short bursts re-requested via GAP.
module image_line_fetcher #(
   parameter int WORDS_PER_LINE = 2160,
   parameter int VISIBLE_LINES  = 720,
   parameter int END_BURST_LEAD = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        line_start,
   input  logic [9:0]  line_y,
   output logic [24:0] sd_addr,
   output logic        sd_rd_req,
   output logic        sd_end_burst,
   input  logic        sd_data_available,
   input  logic [15:0] sd_q,
   output logic        fifo_clear,
   output logic        pixel_valid,
   output logic [23:0] bg_pixel,
   output logic [23:0] mask_pixel,
   output logic        line_done
);

   localparam int            CW     = $clog2(WORDS_PER_LINE + 1);
   localparam logic [CW-1:0] WPL    = CW'(WORDS_PER_LINE);
   localparam logic [CW-1:0] EB_IDX = CW'(WORDS_PER_LINE - END_BURST_LEAD);
   localparam logic [10:0]   VIS    = 11'(VISIBLE_LINES);

   typedef enum logic [2:0] {IDLE, REQUEST, BURST, GAP, DRAIN, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] word_count_q, word_count_d;
   logic [1:0]    pack_count_q, pack_count_d;
   logic [23:0]   bg_buf_q, bg_buf_d, mask_buf_q, mask_buf_d;
   logic [24:0]   line_base_q, line_base_d;
   logic          end_sent_q, end_sent_d;
   logic          dav_prev_q, dav_prev_d;
   logic [24:0]   sd_addr_q, sd_addr_d;
   logic          sd_rd_req_q, sd_rd_req_d;
   logic          sd_end_burst_q, sd_end_burst_d;
   logic          fifo_clear_q, fifo_clear_d;
   logic          pixel_valid_q, pixel_valid_d;
   logic [23:0]   bg_pixel_q, bg_pixel_d, mask_pixel_q, mask_pixel_d;
   logic          line_done_q, line_done_d;

   logic [9:0]    y_sel;
   logic [24:0]   base_new;
   logic [23:0]   bg_shift, mask_shift;

   always_comb begin
      state_d        = state_q;
      word_count_d   = word_count_q;
      pack_count_d   = pack_count_q;
      bg_buf_d       = bg_buf_q;
      mask_buf_d     = mask_buf_q;
      line_base_d    = line_base_q;
      end_sent_d     = end_sent_q;
      dav_prev_d     = sd_data_available;
      sd_addr_d      = sd_addr_q;
      sd_rd_req_d    = 1'b0;
      sd_end_burst_d = 1'b0;
      fifo_clear_d   = 1'b0;
      pixel_valid_d  = 1'b0;
      bg_pixel_d     = bg_pixel_q;
      mask_pixel_d   = mask_pixel_q;
      line_done_d    = line_done_q;

      y_sel      = ({1'b0, line_y} >= VIS) ? 10'd0 : line_y;
      base_new   = 25'(y_sel) * 25'(WORDS_PER_LINE);
      // Newest byte enters at [23:16] so the first byte of a pixel ends up in [7:0].
      bg_shift   = {sd_q[7:0],  bg_buf_q[23:8]};
      mask_shift = {sd_q[15:8], mask_buf_q[23:8]};

      if (line_start) begin
         fifo_clear_d = 1'b1;
         word_count_d = '0;
         pack_count_d = 2'd0;
         bg_buf_d     = '0;
         mask_buf_d   = '0;
         line_base_d  = base_new;
         line_done_d  = 1'b0;
         end_sent_d   = 1'b0;
         if (state_q == BURST || state_q == GAP) begin
            sd_end_burst_d = 1'b1;
            state_d        = DRAIN;
         end else begin
            sd_rd_req_d = 1'b1;
            sd_addr_d   = base_new;
            state_d     = REQUEST;
         end
      end else begin
         case (state_q)
            REQUEST: begin
               end_sent_d = 1'b0;
               state_d    = BURST;
            end
            BURST: begin
               if (sd_data_available) begin
                  if (word_count_q < WPL) begin
                     bg_buf_d     = bg_shift;
                     mask_buf_d   = mask_shift;
                     word_count_d = word_count_q + CW'(1);
                     if (pack_count_q == 2'd2) begin
                        pack_count_d  = 2'd0;
                        pixel_valid_d = 1'b1;
                        bg_pixel_d    = bg_shift;
                        mask_pixel_d  = mask_shift;
                     end else begin
                        pack_count_d = pack_count_q + 2'd1;
                     end
                     if (word_count_q >= EB_IDX && !end_sent_q) begin
                        sd_end_burst_d = 1'b1;
                        end_sent_d     = 1'b1;
                     end
                  end
               end else if (dav_prev_q) begin
                  if (word_count_q < WPL) begin
                     state_d = GAP;
                  end else begin
                     state_d     = DONE;
                     line_done_d = 1'b1;
                  end
               end
            end
            GAP: begin
               sd_rd_req_d = 1'b1;
               sd_addr_d   = line_base_q + 25'(word_count_q);
               state_d     = REQUEST;
            end
            DRAIN: begin
               // The aborted burst's tail is dropped until the controller goes quiet.
               if (!sd_data_available) begin
                  sd_rd_req_d = 1'b1;
                  sd_addr_d   = line_base_q + 25'(word_count_q);
                  state_d     = REQUEST;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         word_count_q   <= '0;
         pack_count_q   <= 2'd0;
         bg_buf_q       <= '0;
         mask_buf_q     <= '0;
         line_base_q    <= '0;
         end_sent_q     <= 1'b0;
         dav_prev_q     <= 1'b0;
         sd_addr_q      <= '0;
         sd_rd_req_q    <= 1'b0;
         sd_end_burst_q <= 1'b0;
         fifo_clear_q   <= 1'b0;
         pixel_valid_q  <= 1'b0;
         bg_pixel_q     <= '0;
         mask_pixel_q   <= '0;
         line_done_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         word_count_q   <= word_count_d;
         pack_count_q   <= pack_count_d;
         bg_buf_q       <= bg_buf_d;
         mask_buf_q     <= mask_buf_d;
         line_base_q    <= line_base_d;
         end_sent_q     <= end_sent_d;
         dav_prev_q     <= dav_prev_d;
         sd_addr_q      <= sd_addr_d;
         sd_rd_req_q    <= sd_rd_req_d;
         sd_end_burst_q <= sd_end_burst_d;
         fifo_clear_q   <= fifo_clear_d;
         pixel_valid_q  <= pixel_valid_d;
         bg_pixel_q     <= bg_pixel_d;
         mask_pixel_q   <= mask_pixel_d;
         line_done_q    <= line_done_d;
      end
   end

   assign sd_addr      = sd_addr_q;
   assign sd_rd_req    = sd_rd_req_q;
   assign sd_end_burst = sd_end_burst_q;
   assign fifo_clear   = fifo_clear_q;
   assign pixel_valid  = pixel_valid_q;
   assign bg_pixel     = bg_pixel_q;
   assign mask_pixel   = mask_pixel_q;
   assign line_done    = line_done_q;

endmodule

// File: tb/tb_image_line_fetcher.sv
// Directed bench for image_line_fetcher: addressing, packing, full/split/aborted line fetches.
module tb_image_line_fetcher;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        line_start;
   logic [9:0]  line_y;
   logic [24:0] sd_addr;
   logic        sd_rd_req;
   logic        sd_end_burst;
   logic        sd_data_available;
   logic [15:0] sd_q;
   logic        fifo_clear;
   logic        pixel_valid;
   logic [23:0] bg_pixel;
   logic [23:0] mask_pixel;
   logic        line_done;

   image_line_fetcher dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .line_start        (line_start),
      .line_y            (line_y),
      .sd_addr           (sd_addr),
      .sd_rd_req         (sd_rd_req),
      .sd_end_burst      (sd_end_burst),
      .sd_data_available (sd_data_available),
      .sd_q              (sd_q),
      .fifo_clear        (fifo_clear),
      .pixel_valid       (pixel_valid),
      .bg_pixel          (bg_pixel),
      .mask_pixel        (mask_pixel),
      .line_done         (line_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Activity monitor, sampled on the falling edge.
   int          cyc = 0;
   logic [47:0] pix_q[$];
   int          eb_cnt = 0, eb_cyc = 0, rq_cnt = 0, rq_cyc = 0, fc_cnt = 0;
   int          done_cyc = 0;
   bit          done_seen = 0;
   logic [24:0] rq_addr = '0;
   int          fall_cyc = 0, eb_word_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pixel_valid) pix_q.push_back({bg_pixel, mask_pixel});
      if (sd_end_burst) begin eb_cnt++; eb_cyc = cyc; end
      if (sd_rd_req) begin rq_cnt++; rq_cyc = cyc; rq_addr = sd_addr; end
      if (fifo_clear) fc_cnt++;
      if (line_done && !done_seen) begin done_seen = 1; done_cyc = cyc; end
   end

   task automatic clear_mon();
      pix_q.delete();
      eb_cnt = 0; rq_cnt = 0; fc_cnt = 0; done_seen = 0; rq_addr = '0;
   endtask

   function automatic logic [15:0] word_of(input int line, input int idx);
      logic [7:0] b, m;
      b = 8'(idx + line * 37);
      m = 8'(idx * 3 + line + (idx >> 8));
      return {m, b};
   endfunction

   function automatic logic [47:0] exp_pix(input int line, input int k);
      logic [15:0] w0, w1, w2;
      w0 = word_of(line, 3 * k);
      w1 = word_of(line, 3 * k + 1);
      w2 = word_of(line, 3 * k + 2);
      return {w2[7:0], w1[7:0], w0[7:0], w2[15:8], w1[15:8], w0[15:8]};
   endfunction

   task automatic check_pixels(input string tag, input int line, input int n);
      chk({tag, "_count"}, 64'(pix_q.size()), 64'(n));
      for (int k = 0; k < pix_q.size() && k < n; k++)
         chk($sformatf("%s_pix%0d", tag, k), 64'(pix_q[k]), 64'(exp_pix(line, k)));
   endtask

   task automatic send_words(input int line, input int first, input int n, input bit drop);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         sd_data_available = 1'b1;
         sd_q = word_of(line, first + j);
         if (first + j == 2158) eb_word_cyc = cyc;
      end
      if (drop) begin
         @(negedge clk);
         sd_data_available = 1'b0;
         fall_cyc = cyc;
      end
   endtask

   task automatic start_line(input int y, output logic [24:0] addr);
      bit got;
      got  = 0;
      addr = '0;
      @(negedge clk);
      line_y = 10'(y);
      line_start = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         line_start = 1'b0;
         if (sd_rd_req) begin got = 1; addr = sd_addr; end
      end
      chk($sformatf("req_seen_y%0d", y), 64'(got), 64'd1);
      #1 clear_mon();
   endtask

   logic [24:0] a;
   logic [15:0] pk[3];
   int          ys[3];
   int          ya[3];

   initial begin
      reset_n = 1'b0; line_start = 1'b0; line_y = '0;
      sd_data_available = 1'b0; sd_q = '0;
      repeat (3) @(negedge clk);
      chk("rst_rd_req", 64'(sd_rd_req), 0);
      chk("rst_end_burst", 64'(sd_end_burst), 0);
      chk("rst_fifo_clear", 64'(fifo_clear), 0);
      chk("rst_pixel_valid", 64'(pixel_valid), 0);
      chk("rst_line_done", 64'(line_done), 0);
      chk("rst_addr", 64'(sd_addr), 0);
      chk("rst_pixels", 64'({bg_pixel, mask_pixel}), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // line_start with y=5: clear and request together one cycle later
      @(negedge clk);
      line_y = 10'd5; line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      chk("y5_fifo_clear", 64'(fifo_clear), 1);
      chk("y5_rd_req", 64'(sd_rd_req), 1);
      chk("y5_addr", 64'(sd_addr), 64'd10800);
      @(negedge clk);
      chk("y5_rd_req_pulse", 64'(sd_rd_req), 0);
      chk("y5_clear_pulse", 64'(fifo_clear), 0);
      #1 clear_mon();

      // Packing of three hand-picked words, then short-burst re-request
      pk = '{16'h1122, 16'h3344, 16'h5566};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         sd_data_available = 1'b1; sd_q = pk[i];
      end
      @(negedge clk);
      sd_data_available = 1'b0; fall_cyc = cyc;
      repeat (3) @(negedge clk);
      #1;
      chk("pack_count", 64'(pix_q.size()), 1);
      if (pix_q.size() > 0) chk("pack_value", 64'(pix_q[0]), 64'({24'h664422, 24'h553311}));
      chk("gap_req_count", 64'(rq_cnt), 1);
      chk("gap_req_addr", 64'(rq_addr), 64'd10803);
      chk("gap_req_delay", 64'(rq_cyc - fall_cyc), 2);
      chk("gap_line_done", 64'(line_done), 0);

      // Full line in one burst with trailing extra words
      start_line(2, a);
      chk("full_addr", 64'(a), 64'd4320);
      send_words(2, 0, 2165, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      check_pixels("full", 2, 720);
      chk("full_eb_count", 64'(eb_cnt), 1);
      chk("full_eb_delay", 64'(eb_cyc - eb_word_cyc), 1);
      chk("full_line_done", 64'(line_done), 1);
      chk("full_done_delay", 64'(done_cyc - fall_cyc), 1);
      chk("full_no_rerequest", 64'(rq_cnt), 0);

      // Split line: 1000 + 1160 words
      start_line(3, a);
      chk("split_addr", 64'(a), 64'd6480);
      chk("split_done_cleared", 64'(line_done), 0);
      send_words(3, 0, 1000, 1'b1);
      repeat (4) @(negedge clk);
      #1;
      chk("split_req_count", 64'(rq_cnt), 1);
      chk("split_req_addr", 64'(rq_addr), 64'd7480);
      chk("split_req_delay", 64'(rq_cyc - fall_cyc), 2);
      send_words(3, 1000, 1160, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      check_pixels("split", 3, 720);
      chk("split_eb_count", 64'(eb_cnt), 1);
      chk("split_eb_delay", 64'(eb_cyc - eb_word_cyc), 1);
      chk("split_line_done", 64'(line_done), 1);
      chk("split_req_total", 64'(rq_cnt), 1);

      // Out-of-range and last visible line addresses
      ys = '{720, 1023, 719};
      ya = '{0, 0, 1553040};
      for (int i = 0; i < 3; i++) begin
         start_line(ys[i], a);
         chk($sformatf("addr_y%0d", ys[i]), 64'(a), 64'(ya[i]));
      end

      // Abort mid-burst at word 500 with a new line_start
      start_line(4, a);
      chk("abort_addr", 64'(a), 64'd8640);
      send_words(4, 0, 500, 1'b0);
      @(negedge clk);
      line_start = 1'b1; line_y = 10'd6; sd_q = word_of(4, 500);
      #1;
      chk("abort_pix_before", 64'(pix_q.size()), 166);
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         line_start = 1'b0; sd_q = word_of(4, 501 + j);
      end
      @(negedge clk);
      sd_data_available = 1'b0; fall_cyc = cyc;
      repeat (3) @(negedge clk);
      #1;
      chk("abort_eb_count", 64'(eb_cnt), 1);
      chk("abort_fifo_clear", 64'(fc_cnt), 1);
      chk("abort_pix_ignored", 64'(pix_q.size()), 166);
      chk("abort_req_count", 64'(rq_cnt), 1);
      chk("abort_req_addr", 64'(rq_addr), 64'd12960);
      chk("abort_req_delay", 64'(rq_cyc - fall_cyc), 1);
      clear_mon();
      send_words(6, 0, 6, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      check_pixels("abort_new", 6, 2);
      chk("abort_new_rereq", 64'(rq_addr), 64'd12966);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
